branch_predictor_btb: RTL and testbench

- Parametrised direction predictor plus branch target buffer. Replaces the single-state guess predictor.
- Sits beside Reg_PC in IF. Combinationally supplies the predicted next PC for the PC currently being fetched.
- Trained from the E/M pipeline register when a branch or jump resolves.
- Adds per-entry N-bit saturating counters, tagged targets, unconditional-jump handling, bulk invalidate and saturating statistics.

---
 rtl/branch_predictor_btb.sv | 127 ++++++++++++
 tb/tb_branch_predictor_btb.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_btb.sv
// Direction predictor plus branch target buffer for the IF stage.
// Zero-latency tagged lookup, trained from E/M, with saturating statistics.
module branch_predictor_btb #(
   parameter int PC_W   = 32,
   parameter int IDX_W  = 6,
   parameter int TAG_W  = 8,
   parameter int CNT_W  = 2,
   parameter int STAT_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [PC_W-1:0]   lookup_pc,
   output logic              pred_hit,
   output logic              pred_taken,
   output logic [PC_W-1:0]   pred_next_pc,
   input  logic              upd_valid,
   input  logic [PC_W-1:0]   upd_pc,
   input  logic              upd_is_cond,
   input  logic              upd_taken,
   input  logic [PC_W-1:0]   upd_target,
   input  logic              upd_mispredict,
   input  logic              inv_all,
   output logic [STAT_W-1:0] stat_branches,
   output logic [STAT_W-1:0] stat_mispredicts
);

   localparam int N = 1 << IDX_W;
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
   localparam logic [CNT_W-1:0]  CNT_WT   = CNT_ONE << (CNT_W - 1);
   localparam logic [CNT_W-1:0]  CNT_WNT  = CNT_WT - CNT_ONE;
   localparam logic [STAT_W-1:0] STAT_MAX = '1;

   logic [N-1:0]                  valid_q, valid_d;
   logic [N-1:0][TAG_W-1:0]       tag_q, tag_d;
   logic [N-1:0][PC_W-1:0]        target_q, target_d;
   logic [N-1:0]                  uncond_q, uncond_d;
   logic [N-1:0][CNT_W-1:0]       cnt_q, cnt_d;
   logic [STAT_W-1:0]             stat_branches_q, stat_branches_d;
   logic [STAT_W-1:0]             stat_mispredicts_q, stat_mispredicts_d;

   logic [IDX_W-1:0] lk_idx, up_idx;
   logic [TAG_W-1:0] lk_tag, up_tag;
   logic             up_hit;
   logic             unused_upd_bits;

   assign lk_idx = lookup_pc[IDX_W+1:2];
   assign lk_tag = lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
   assign up_idx = upd_pc[IDX_W+1:2];
   assign up_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
   assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
   assign unused_upd_bits = ^{upd_pc[PC_W-1:IDX_W+TAG_W+2], upd_pc[1:0]};

   // Lookup reads only registered state, so a same-cycle update is never bypassed.
   always_comb begin
      pred_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
      pred_taken   = pred_hit && (uncond_q[lk_idx] || cnt_q[lk_idx][CNT_W-1]);
      pred_next_pc = pred_taken ? target_q[lk_idx] : lookup_pc + PC_W'(4);
   end

   always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      uncond_d = uncond_q;
      cnt_d    = cnt_q;
      if (inv_all) begin
         valid_d = '0;
      end else if (upd_valid) begin
         if (up_hit) begin
            if (upd_is_cond) begin
               uncond_d[up_idx] = 1'b0;
               if (upd_taken) begin
                  target_d[up_idx] = upd_target;
                  if (cnt_q[up_idx] != CNT_MAX) cnt_d[up_idx] = cnt_q[up_idx] + CNT_ONE;
               end else if (cnt_q[up_idx] != '0) begin
                  cnt_d[up_idx] = cnt_q[up_idx] - CNT_ONE;
               end
            end else begin
               target_d[up_idx] = upd_target;
               uncond_d[up_idx] = 1'b1;
               cnt_d[up_idx]    = CNT_MAX;
            end
         end else if (upd_taken) begin
            // Allocation silently evicts whatever aliased into this index.
            valid_d[up_idx]  = 1'b1;
            tag_d[up_idx]    = up_tag;
            target_d[up_idx] = upd_target;
            uncond_d[up_idx] = !upd_is_cond;
            cnt_d[up_idx]    = upd_is_cond ? CNT_WT : CNT_MAX;
         end
      end
   end

   always_comb begin
      stat_branches_d    = stat_branches_q;
      stat_mispredicts_d = stat_mispredicts_q;
      if (upd_valid && (stat_branches_q != STAT_MAX))
         stat_branches_d = stat_branches_q + STAT_W'(1);
      if (upd_valid && upd_mispredict && (stat_mispredicts_q != STAT_MAX))
         stat_mispredicts_d = stat_mispredicts_q + STAT_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q            <= '0;
         tag_q              <= '0;
         target_q           <= '0;
         uncond_q           <= '0;
         cnt_q              <= {N{CNT_WNT}};
         stat_branches_q    <= '0;
         stat_mispredicts_q <= '0;
      end else begin
         valid_q            <= valid_d;
         tag_q              <= tag_d;
         target_q           <= target_d;
         uncond_q           <= uncond_d;
         cnt_q              <= cnt_d;
         stat_branches_q    <= stat_branches_d;
         stat_mispredicts_q <= stat_mispredicts_d;
      end
   end

   assign stat_branches    = stat_branches_q;
   assign stat_mispredicts = stat_mispredicts_q;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Bench for branch_predictor_btb: directed plan plus random traffic,
// checked every cycle against a table-level behavioural model.
module tb_branch_predictor_btb;

   localparam int PC_W   = 32;
   localparam int IDX_W  = 6;
   localparam int TAG_W  = 8;
   localparam int CNT_W  = 2;
   localparam int STAT_W = 4;
   localparam int N      = 64;
   localparam int EW     = 2 + PC_W + 2 * STAT_W;

   logic              clk, rst;
   logic [PC_W-1:0]   lookup_pc, upd_pc, upd_target, pred_next_pc;
   logic              pred_hit, pred_taken;
   logic              upd_valid, upd_is_cond, upd_taken, upd_mispredict, inv_all;
   logic [STAT_W-1:0] stat_branches, stat_mispredicts;

   int checks   = 0;
   int failures = 0;
   logic [EW-1:0] exp_q[$];

   branch_predictor_btb #(
      .PC_W(PC_W), .IDX_W(IDX_W), .TAG_W(TAG_W), .CNT_W(CNT_W), .STAT_W(STAT_W)
   ) dut (
      .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
      .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_next_pc(pred_next_pc),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_cond(upd_is_cond),
      .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispredict(upd_mispredict),
      .inv_all(inv_all), .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // behavioural model: one record per table slot, counters as plain ints
   bit          m_valid[N];
   int unsigned m_tag[N];
   logic [31:0] m_tgt[N];
   bit          m_unc[N];
   int          m_cnt[N];
   int          m_sb, m_sm;

   function automatic void model_reset();
      for (int i = 0; i < N; i++) begin
         m_valid[i] = 0;
         m_cnt[i]   = 1;
      end
      m_sb = 0;
      m_sm = 0;
   endfunction

   function automatic logic [EW-1:0] model_expect();
      int          i;
      bit          hit, tk;
      logic [31:0] nxt;
      i   = int'((lookup_pc >> 2) % N);
      hit = m_valid[i] && (m_tag[i] == ((lookup_pc >> 8) % 256));
      tk  = hit && (m_unc[i] || m_cnt[i] >= 2);
      nxt = lookup_pc + 32'd4;
      if (tk) nxt = m_tgt[i];
      return {hit, tk, nxt, STAT_W'(m_sb), STAT_W'(m_sm)};
   endfunction

   function automatic void model_update();
      int i;
      bit hit;
      i   = int'((upd_pc >> 2) % N);
      hit = m_valid[i] && (m_tag[i] == ((upd_pc >> 8) % 256));
      if (upd_valid) begin
         if (m_sb < 15) m_sb++;
         if (upd_mispredict && m_sm < 15) m_sm++;
      end
      if (inv_all) begin
         for (int k = 0; k < N; k++) m_valid[k] = 0;
      end else if (upd_valid) begin
         if (hit && upd_is_cond) begin
            m_unc[i] = 0;
            if (upd_taken) begin
               m_tgt[i] = upd_target;
               m_cnt[i] = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
            end else begin
               m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
            end
         end else if (hit) begin
            m_tgt[i] = upd_target;
            m_unc[i] = 1;
            m_cnt[i] = 3;
         end else if (upd_taken) begin
            m_valid[i] = 1;
            m_tag[i]   = (upd_pc >> 8) % 256;
            m_tgt[i]   = upd_target;
            m_unc[i]   = !upd_is_cond;
            m_cnt[i]   = upd_is_cond ? 2 : 3;
         end
      end
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // scoreboard: one expected output set per cycle, compared on the falling edge
   always @(negedge clk) begin
      logic [EW-1:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("cyc_hit",   64'(pred_hit),         64'(e[EW-1]));
         chk("cyc_taken", 64'(pred_taken),       64'(e[EW-2]));
         chk("cyc_next",  64'(pred_next_pc),     64'(e[EW-3 -: PC_W]));
         chk("cyc_sb",    64'(stat_branches),    64'(e[2*STAT_W-1 -: STAT_W]));
         chk("cyc_sm",    64'(stat_mispredicts), 64'(e[STAT_W-1:0]));
      end
   end

   // driver tasks
   task automatic set_in(input logic [31:0] lpc, input logic uv, input logic [31:0] upc,
                         input logic cond, input logic tk, input logic [31:0] tgt,
                         input logic mp, input logic inv);
      lookup_pc      = lpc;
      upd_valid      = uv;
      upd_pc         = upc;
      upd_is_cond    = cond;
      upd_taken      = tk;
      upd_target     = tgt;
      upd_mispredict = mp;
      inv_all        = inv;
   endtask

   task automatic finish_cycle();
      exp_q.push_back(model_expect());
      @(posedge clk);
      if (rst) model_update();
      #1;
   endtask

   task automatic drive(input logic [31:0] lpc, input logic uv, input logic [31:0] upc,
                        input logic cond, input logic tk, input logic [31:0] tgt,
                        input logic mp, input logic inv);
      set_in(lpc, uv, upc, cond, tk, tgt, mp, inv);
      finish_cycle();
   endtask

   task automatic peek(input string name, input logic [31:0] lpc, input logic eh,
                       input logic et, input logic [31:0] en);
      set_in(lpc, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk({name, "_hit"},   64'(pred_hit),     64'(eh));
      chk({name, "_taken"}, 64'(pred_taken),   64'(et));
      chk({name, "_next"},  64'(pred_next_pc), 64'(en));
      finish_cycle();
   endtask

   task automatic do_reset();
      rst = 1'b0;
      model_reset();
      finish_cycle();
      finish_cycle();
      rst = 1'b1;
   endtask

   function automatic logic [31:0] pick_pc();
      return (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 3)) << 2)
             | 32'($urandom_range(0, 3));
   endfunction

   initial begin
      rst = 1'b0;
      set_in(32'h100, 0, 0, 0, 0, 0, 0, 0);
      model_reset();
      @(posedge clk);
      #1;
      // 1. reset values
      chk("rst_hit",   64'(pred_hit), 64'd0);
      chk("rst_taken", 64'(pred_taken), 64'd0);
      chk("rst_next",  64'(pred_next_pc), 64'h104);
      chk("rst_sb",    64'(stat_branches), 64'd0);
      chk("rst_sm",    64'(stat_mispredicts), 64'd0);
      do_reset();

      // 2. conditional training
      drive(32'h100, 1, 32'h100, 1, 1, 32'h80, 1, 0);
      peek("alloc", 32'h100, 1, 1, 32'h80);
      repeat (2) drive(32'h0, 1, 32'h100, 1, 0, 32'h0, 0, 0);
      peek("nt2", 32'h100, 1, 0, 32'h104);
      repeat (4) drive(32'h0, 1, 32'h100, 1, 1, 32'h80, 0, 0);
      drive(32'h0, 1, 32'h100, 1, 0, 32'h0, 0, 0);
      peek("sat_nt1", 32'h100, 1, 1, 32'h80);

      // 3. aliasing
      peek("alias_miss", 32'h200, 0, 0, 32'h204);
      drive(32'h0, 1, 32'h200, 1, 1, 32'h500, 0, 0);
      peek("alias_new", 32'h200, 1, 1, 32'h500);
      peek("alias_old", 32'h100, 0, 0, 32'h104);
      drive(32'h0, 1, 32'h300, 1, 0, 32'h700, 0, 0);
      peek("no_alloc", 32'h300, 0, 0, 32'h304);

      // 4. unconditional, same-cycle lookup, wrap
      set_in(32'h40, 1, 32'h40, 0, 1, 32'h300, 0, 0);
      #1;
      chk("bypass_hit",  64'(pred_hit), 64'd0);
      chk("bypass_next", 64'(pred_next_pc), 64'h44);
      finish_cycle();
      peek("jal", 32'h40, 1, 1, 32'h300);
      peek("wrap", 32'hFFFF_FFFC, 0, 0, 32'h0);

      // 5. invalidate wins over simultaneous update; stats still count
      drive(32'h0, 1, 32'h100, 1, 1, 32'h80, 0, 1);
      peek("inv_a", 32'h40, 0, 0, 32'h44);
      peek("inv_b", 32'h100, 0, 0, 32'h104);
      peek("inv_c", 32'h200, 0, 0, 32'h204);
      chk("inv_sb", 64'(stat_branches), 64'd12);
      chk("inv_sm", 64'(stat_mispredicts), 64'd1);

      // 6. statistics saturation, then asynchronous reset mid-update
      do_reset();
      for (int k = 0; k < 20; k++)
         drive(32'h0, 1, 32'h40, 1, 1, 32'h900, logic'(k % 2 == 0), 0);
      chk("sat_sb", 64'(stat_branches), 64'd15);
      chk("sat_sm", 64'(stat_mispredicts), 64'd10);
      set_in(32'h40, 1, 32'h40, 0, 1, 32'h123, 1, 0);
      #1;
      chk("pre_rst_hit", 64'(pred_hit), 64'd1);
      rst = 1'b0;
      model_reset();
      #1;
      chk("async_hit",   64'(pred_hit), 64'd0);
      chk("async_taken", 64'(pred_taken), 64'd0);
      chk("async_next",  64'(pred_next_pc), 64'h44);
      chk("async_sb",    64'(stat_branches), 64'd0);
      finish_cycle();
      rst = 1'b1;
      peek("post_rst", 32'h40, 0, 0, 32'h44);

      // random traffic against the model
      for (int k = 0; k < 400; k++)
         drive(pick_pc(), logic'($urandom_range(0, 1)), pick_pc(),
               logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
               $urandom & 32'hFFFF_FFFC, logic'($urandom_range(0, 1)),
               logic'($urandom_range(0, 39) == 0));

      set_in(32'h0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
